conv_unit: RTL and testbench

Custom-instruction convolution accelerator attached to the core's issue stage as a co-processor. It decodes three custom-0 instructions: set bases, set sizes, and run one output point. It fetches kernel and input words through a dedicated LSU request port and returns each dot-product result as a writeback value. Each RUN produces one output of a 1-D sliding dot product of a K·K-tap kernel over an input vector. The input window advances by one word per RUN.

---
 rtl/conv_unit.sv | 218 +++++++++++++++++++++
 tb/tb_conv_unit.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_unit.sv
// conv_unit: custom-0 co-processor computing one point of a 1-D sliding
// dot product per RUN instruction, fetching operands over a private LSU port.
// Optional feature macro: CONV_KERNEL_PRELOAD_EN (kernel cached at SETSIZE;
// RUN then fetches only input words). Without it RUN interleaves kernel and
// input loads. Results are identical in both builds.
//
// LSU handshake: a request transfers on a cycle where lsu_req_o=1 and
// lsu_req_ready_i=1; lsu_addr_o holds steady while lsu_req_o=1 and ready=0.
// Responses come back one per lsu_data_valid_i pulse, in request order.
module conv_unit #(
    parameter int KMAX = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        opcode_valid_i,
    input  logic [31:0] opcode_opcode_i,
    input  logic        opcode_invalid_i,
    input  logic [31:0] opcode_ra_operand_i,
    input  logic [31:0] opcode_rb_operand_i,
    output logic        lsu_req_o,
    output logic [31:0] lsu_addr_o,
    input  logic        lsu_req_ready_i,
    input  logic        lsu_data_valid_i,
    input  logic [31:0] lsu_data_i,
    output logic        busy_o,
    output logic        valid_o,
    output logic [31:0] writeback_o
);
    localparam int          TMAX = 2 * KMAX * KMAX;
    localparam int          CW   = $clog2(TMAX + 1) + 1;
    localparam logic [6:0]  OPC_CUSTOM0 = 7'b0001011;

    typedef enum logic [2:0] {IDLE, PRELOAD, RUN_ISSUE, RUN_DRAIN, DONE} state_e;

    state_e         state_q, state_d;
    logic [31:0]    kbase_q, kbase_d, xbase_q, xbase_d;
    logic [31:0]    n_q, n_d, k_q, k_d, off_q, off_d;
    logic [CW-1:0]  req_cnt_q, req_cnt_d, rsp_cnt_q, rsp_cnt_d, outst_q, outst_d;
    logic [31:0]    acc_q, acc_d, wb_q, wb_d;

    logic           accept, k_ok, rb_ok, req_fire, rsp_fire, acc_en;
    logic           last_req, last_rsp;
    logic [2:0]     funct3;
    logic [CW-1:0]  k_lo, k_sq, req_total;
    logic [31:0]    req_w, addr, kern_w, prod, acc_upd, off_inc, off_adv;
    logic           unused_opcode_bits;

    assign unused_opcode_bits = ^{opcode_opcode_i[31:15], opcode_opcode_i[11:7]};

    assign busy_o   = (state_q == PRELOAD) || (state_q == RUN_ISSUE) || (state_q == RUN_DRAIN);
    assign valid_o  = (state_q == DONE);
    assign writeback_o = wb_q;
    assign funct3   = opcode_opcode_i[14:12];
    assign accept   = opcode_valid_i && !opcode_invalid_i
                    && (opcode_opcode_i[6:0] == OPC_CUSTOM0) && !busy_o;
    assign k_ok     = (k_q != 32'd0) && (k_q <= 32'(KMAX));
    assign rb_ok    = (opcode_rb_operand_i != 32'd0) && (opcode_rb_operand_i <= 32'(KMAX));
    assign k_lo     = k_q[CW-1:0];
    assign k_sq     = k_lo * k_lo;
    assign req_w    = 32'(req_cnt_q);
    assign off_inc  = off_q + 32'd1;
    // Window offset wraps once it would run past the last full window.
    assign off_adv  = (off_inc == n_q - k_q + 32'd1) ? 32'd0 : off_inc;

`ifdef CONV_KERNEL_PRELOAD_EN
    localparam int KIW = $clog2(KMAX * KMAX);
    logic [31:0] kern_mem [KMAX*KMAX];

    assign req_total = k_sq;
    assign lsu_req_o = (state_q == RUN_ISSUE) || ((state_q == PRELOAD) && (req_cnt_q != k_sq));
    assign addr      = (state_q == PRELOAD) ? kbase_q + (req_w << 2)
                                            : xbase_q + ((off_q + req_w) << 2);
    assign kern_w    = kern_mem[rsp_cnt_q[KIW-1:0]];
    assign acc_en    = rsp_fire && (state_q != PRELOAD);

    // Kernel cache fill during PRELOAD; contents are not reset.
    always_ff @(posedge clk) begin
        if (!rst && rsp_fire && (state_q == PRELOAD))
            kern_mem[rsp_cnt_q[KIW-1:0]] <= lsu_data_i;
    end
`else
    logic [31:0] kreg_q, kreg_d;
    logic [31:0] idx_w;

    assign req_total = k_sq << 1;
    assign lsu_req_o = (state_q == RUN_ISSUE);
    assign idx_w     = req_w >> 1;
    // Even requests fetch kernel word i, odd requests fetch input word off+i.
    assign addr      = req_cnt_q[0] ? xbase_q + ((off_q + idx_w) << 2)
                                    : kbase_q + (idx_w << 2);
    assign kern_w    = kreg_q;
    assign acc_en    = rsp_fire && rsp_cnt_q[0];

    // Holds the kernel word until its paired input word returns.
    always_comb begin
        kreg_d = kreg_q;
        if (rsp_fire && !rsp_cnt_q[0]) kreg_d = lsu_data_i;
    end

    // Kernel word holding register.
    always_ff @(posedge clk) begin
        if (rst) kreg_q <= 32'd0;
        else     kreg_q <= kreg_d;
    end
`endif

    assign lsu_addr_o = lsu_req_o ? addr : 32'd0;
    assign req_fire   = lsu_req_o && lsu_req_ready_i;
    // Stray data (nothing outstanding, or while idle) is dropped.
    assign rsp_fire   = lsu_data_valid_i && (outst_q != '0) && (state_q != IDLE);
    assign last_req   = (req_cnt_q == req_total - CW'(1));
    assign last_rsp   = (rsp_cnt_q == req_total - CW'(1));
    // Low 32 bits of a signed product equal those of the unsigned product.
    assign prod       = kern_w * lsu_data_i;
    assign acc_upd    = acc_q + prod;

    // Next-state and register-update logic for the instruction FSM.
    always_comb begin
        state_d   = state_q;
        kbase_d   = kbase_q;
        xbase_d   = xbase_q;
        n_d       = n_q;
        k_d       = k_q;
        off_d     = off_q;
        req_cnt_d = req_cnt_q;
        rsp_cnt_d = rsp_cnt_q;
        outst_d   = outst_q;
        acc_d     = acc_q;
        wb_d      = wb_q;

        if (busy_o)
            outst_d = outst_q + CW'(req_fire) - CW'(rsp_fire);
        if (req_fire)
            req_cnt_d = req_cnt_q + CW'(1);
        if (rsp_fire)
            rsp_cnt_d = rsp_cnt_q + CW'(1);
        if (acc_en)
            acc_d = acc_upd;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                req_cnt_d = '0;
                rsp_cnt_d = '0;
                outst_d   = '0;
                if (accept) begin
                    case (funct3)
                        3'b000: begin
                            kbase_d = opcode_ra_operand_i;
                            xbase_d = opcode_rb_operand_i;
                            off_d   = 32'd0;
                        end
                        3'b001: begin
                            n_d   = opcode_ra_operand_i;
                            k_d   = opcode_rb_operand_i;
                            off_d = 32'd0;
`ifdef CONV_KERNEL_PRELOAD_EN
                            if (rb_ok) state_d = PRELOAD;
`endif
                        end
                        3'b010: begin
                            acc_d = 32'd0;
                            if (k_ok) begin
                                state_d = RUN_ISSUE;
                            end else begin
                                state_d = DONE;
                                wb_d    = 32'd0;
                                off_d   = off_adv;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            PRELOAD: begin
                if (rsp_fire && last_rsp) state_d = IDLE;
            end
            RUN_ISSUE, RUN_DRAIN: begin
                if (state_q == RUN_ISSUE && req_fire && last_req) state_d = RUN_DRAIN;
                if (rsp_fire && last_rsp) begin
                    state_d = DONE;
                    wb_d    = acc_upd;
                    off_d   = off_adv;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            kbase_q   <= 32'd0;
            xbase_q   <= 32'd0;
            n_q       <= 32'd0;
            k_q       <= 32'd0;
            off_q     <= 32'd0;
            req_cnt_q <= '0;
            rsp_cnt_q <= '0;
            outst_q   <= '0;
            acc_q     <= 32'd0;
            wb_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            kbase_q   <= kbase_d;
            xbase_q   <= xbase_d;
            n_q       <= n_d;
            k_q       <= k_d;
            off_q     <= off_d;
            req_cnt_q <= req_cnt_d;
            rsp_cnt_q <= rsp_cnt_d;
            outst_q   <= outst_d;
            acc_q     <= acc_d;
            wb_q      <= wb_d;
        end
    end
endmodule

// File: tb/tb_conv_unit.sv
// tb_conv_unit: self-checking bench for conv_unit with an LSU memory model,
// a behavioural dot-product reference and an expected-result queue.
module tb_conv_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        opcode_valid_i = 1'b0;
    logic [31:0] opcode_opcode_i = 32'd0;
    logic        opcode_invalid_i = 1'b0;
    logic [31:0] opcode_ra_operand_i = 32'd0;
    logic [31:0] opcode_rb_operand_i = 32'd0;
    logic        lsu_req_o;
    logic [31:0] lsu_addr_o;
    logic        lsu_req_ready_i = 1'b1;
    logic        lsu_data_valid_i = 1'b0;
    logic [31:0] lsu_data_i = 32'd0;
    logic        busy_o, valid_o;
    logic [31:0] writeback_o;

    always #5 clk = ~clk;

    conv_unit #(.KMAX(9)) dut (
        .clk(clk), .rst(rst),
        .opcode_valid_i(opcode_valid_i), .opcode_opcode_i(opcode_opcode_i),
        .opcode_invalid_i(opcode_invalid_i),
        .opcode_ra_operand_i(opcode_ra_operand_i), .opcode_rb_operand_i(opcode_rb_operand_i),
        .lsu_req_o(lsu_req_o), .lsu_addr_o(lsu_addr_o), .lsu_req_ready_i(lsu_req_ready_i),
        .lsu_data_valid_i(lsu_data_valid_i), .lsu_data_i(lsu_data_i),
        .busy_o(busy_o), .valid_o(valid_o), .writeback_o(writeback_o)
    );

    int checks = 0;
    int errors = 0;

    // Word-addressed backing memory seen through the LSU model.
    logic [31:0] mem [1024];
    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        return mem[a[11:2]];
    endfunction

    // LSU model: accepts per ready policy, returns data lat cycles later in order.
    int          lat = 1;
    int          rdy_mode = 0;
    int          cyc = 0;
    logic [31:0] rq_data[$];
    int          rq_due[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    always @(negedge clk) begin
        cyc = cyc + 1;
        lsu_data_valid_i = 1'b0;
        lsu_data_i = 32'd0;
        if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
            lsu_data_valid_i = 1'b1;
            lsu_data_i = rq_data.pop_front();
            void'(rq_due.pop_front());
        end
        case (rdy_mode)
            0: lsu_req_ready_i = 1'b1;
            1: lsu_req_ready_i = cyc[0];
            default: lsu_req_ready_i = 1'($urandom_range(0, 1));
        endcase
        if (lsu_req_o === 1'b1 && prev_stall) begin
            checks++;
            if (lsu_addr_o !== prev_addr) begin
                errors++;
                $display("FAIL addr_hold: addr %h changed from %h while stalled", lsu_addr_o, prev_addr);
            end
        end
        if (lsu_req_o === 1'b1 && lsu_req_ready_i) begin
            rq_data.push_back(rd_mem(lsu_addr_o));
            rq_due.push_back(cyc + lat);
        end
        prev_stall = (lsu_req_o === 1'b1) && !lsu_req_ready_i;
        prev_addr  = lsu_addr_o;
    end

    // Scoreboard: every valid_o pulse consumes one expected result.
    logic [31:0] exp_q[$];
    int          n_valid = 0;
    always @(negedge clk) begin
        if (valid_o === 1'b1) begin
            n_valid++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: writeback %0d with nothing expected", writeback_o);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (writeback_o !== e) begin
                    errors++;
                    $display("FAIL result: writeback %0d expected %0d", writeback_o, e);
                end
            end
        end
    end

    // Reference model of the architectural registers.
    logic [31:0] m_kbase = 0, m_xbase = 0, m_n = 0, m_k = 0, m_off = 0;

    function automatic logic [31:0] model_y();
        logic [31:0] sum;
        sum = 32'd0;
        if (m_k == 0 || m_k > 9) return 32'd0;
        for (int i = 0; i < int'(m_k * m_k); i++)
            sum = sum + rd_mem(m_kbase + 4 * i) * rd_mem(m_xbase + 4 * (m_off + i));
        return sum;
    endfunction

    task automatic model_reset();
        m_kbase = 0; m_xbase = 0; m_n = 0; m_k = 0; m_off = 0;
        exp_q.delete();
    endtask

    task automatic raw(input logic [2:0] f3, input logic [31:0] ra, input logic [31:0] rb,
                       input logic inv, input logic [6:0] opc);
        @(negedge clk);
        opcode_valid_i      = 1'b1;
        opcode_invalid_i    = inv;
        opcode_opcode_i     = {7'h5a, 5'd2, 5'd1, f3, 5'd3, opc};
        opcode_ra_operand_i = ra;
        opcode_rb_operand_i = rb;
        @(negedge clk);
        opcode_valid_i   = 1'b0;
        opcode_invalid_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        while (busy_o === 1'b1 && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (c >= budget) begin
            errors++;
            $display("FAIL idle_timeout: busy_o still %b after %0d cycles", busy_o, budget);
        end
    endtask

    task automatic wait_results(input int target, input int budget);
        int c;
        c = 0;
        while (n_valid < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (n_valid < target) begin
            errors++;
            $display("FAIL result_timeout: got %0d results need %0d", n_valid, target);
        end
    endtask

    // Issue an accepted instruction and mirror its effect in the model.
    task automatic issue(input logic [2:0] f3, input logic [31:0] ra, input logic [31:0] rb);
        wait_idle(1000);
        case (f3)
            3'b000: begin m_kbase = ra; m_xbase = rb; m_off = 0; end
            3'b001: begin m_n = ra; m_k = rb; m_off = 0; end
            3'b010: begin
                exp_q.push_back(model_y());
                m_off = m_off + 1;
                if (m_off == m_n - m_k + 1) m_off = 0;
            end
            default: ;
        endcase
        raw(f3, ra, rb, 1'b0, 7'b0001011);
    endtask

    task automatic run_one(output logic [31:0] wb);
        int v0;
        v0 = n_valid;
        issue(3'b010, 0, 0);
        wait_results(v0 + 1, 600);
        wb = writeback_o;
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if ({lsu_req_o, lsu_addr_o, busy_o, valid_o, writeback_o} !== 67'd0) begin
            errors++;
            $display("FAIL %s: req %b addr %h busy %b valid %b wb %h required all 0",
                     name, lsu_req_o, lsu_addr_o, busy_o, valid_o, writeback_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_state");
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_setup_no_valid();
        int v0;
        v0 = n_valid;
        issue(3'b000, 0, 324);
        issue(3'b001, 200, 9);
        wait_idle(300);
        repeat (5) @(negedge clk);
        checks++;
        if (n_valid !== v0) begin
            errors++;
            $display("FAIL setup_no_valid: %0d pulses required 0", n_valid - v0);
        end
    endtask

    task automatic test_sweep();
        int v0;
        logic [31:0] wb, last;
        v0 = n_valid;
        for (int j = 0; j < 192; j++) begin
            last = model_y();
            run_one(wb);
            if (j == 0 || j == 1) begin
                checks++;
                if (wb !== ((j == 0) ? 32'd177120 : 32'd180441)) begin
                    errors++;
                    $display("FAIL sweep_y%0d: got %0d", j, wb);
                end
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if (n_valid - v0 !== 192 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL sweep_count: %0d results required 192", n_valid - v0);
        end
        checks++;
        if (writeback_o !== last) begin
            errors++;
            $display("FAIL wb_hold: writeback %0d required %0d", writeback_o, last);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] want [5];
        logic [31:0] wb;
        want[0] = 177120; want[1] = 180441; want[2] = 183762; want[3] = 187083; want[4] = 177120;
        issue(3'b000, 0, 324);
        issue(3'b001, 12, 9);
        for (int j = 0; j < 5; j++) begin
            run_one(wb);
            checks++;
            if (wb !== want[j]) begin
                errors++;
                $display("FAIL wrap_run%0d: got %0d required %0d", j, wb, want[j]);
            end
        end
    endtask

    task automatic test_busy_drop();
        int v0;
        logic [31:0] wb;
        v0 = n_valid;
        issue(3'b010, 0, 0);
        repeat (3) @(negedge clk);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL busy_during_run: busy_o %b required 1", busy_o);
        end
        raw(3'b010, 0, 0, 1'b0, 7'b0001011);
        wait_results(v0 + 1, 600);
        repeat (250) @(negedge clk);
        checks++;
        if (n_valid - v0 !== 1) begin
            errors++;
            $display("FAIL busy_drop_count: %0d results required 1", n_valid - v0);
        end
        run_one(wb);
    endtask

    task automatic test_ignored();
        logic [2:0] f3s [3];
        logic       invs [3];
        logic [6:0] opcs [3];
        f3s[0] = 3'b010; invs[0] = 1'b1; opcs[0] = 7'b0001011;
        f3s[1] = 3'b010; invs[1] = 1'b0; opcs[1] = 7'b0101011;
        f3s[2] = 3'b011; invs[2] = 1'b0; opcs[2] = 7'b0001011;
        for (int c = 0; c < 3; c++) begin
            logic seen;
            seen = 1'b0;
            raw(f3s[c], 0, 0, invs[c], opcs[c]);
            for (int t = 0; t < 20; t++) begin
                if (busy_o !== 1'b0 || valid_o !== 1'b0 || lsu_req_o !== 1'b0) seen = 1'b1;
                @(negedge clk);
            end
            checks++;
            if (seen !== 1'b0) begin
                errors++;
                $display("FAIL ignored_case%0d: activity %b required 0", c, seen);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] wb;
        rdy_mode = 1;
        lat = 3;
        issue(3'b000, 0, 324);
        issue(3'b001, 200, 9);
        for (int j = 0; j < 3; j++) run_one(wb);
        rdy_mode = 2;
        for (int j = 0; j < 2; j++) run_one(wb);
        wait_idle(300);
        repeat (6) @(negedge clk);
        rdy_mode = 0;
        lat = 1;
    endtask

    task automatic test_random();
        logic [31:0] wb;
        for (int w = 400; w < 1024; w++) mem[w] = $urandom;
        for (int it = 0; it < 8; it++) begin
            int kk;
            kk = $urandom_range(0, 10);
            lat = $urandom_range(1, 3);
            rdy_mode = $urandom_range(0, 2);
            issue(3'b000, 4 * $urandom_range(400, 499), 4 * $urandom_range(600, 699));
            issue(3'b001, kk + $urandom_range(0, 3), kk);
            for (int j = 0; j < 4; j++) run_one(wb);
            wait_idle(300);
            repeat (6) @(negedge clk);
        end
        rdy_mode = 0;
        lat = 1;
    endtask

    task automatic test_reset_mid();
        int c;
        int v0;
        logic [31:0] wb;
        issue(3'b000, 0, 324);
        issue(3'b001, 200, 9);
        issue(3'b010, 0, 0);
        c = 0;
        while (lsu_req_o !== 1'b1 && c < 50) begin @(negedge clk); c++; end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("reset_mid_run");
        rst = 1'b0;
        model_reset();
        v0 = n_valid;
        repeat (20) @(negedge clk);
        checks++;
        if (n_valid !== v0) begin
            errors++;
            $display("FAIL reset_late_valid: %0d pulses after reset required 0", n_valid - v0);
        end
        issue(3'b000, 0, 324);
        issue(3'b001, 200, 9);
        run_one(wb);
        checks++;
        if (wb !== 32'd177120) begin
            errors++;
            $display("FAIL after_reset_run: got %0d required 177120", wb);
        end
    endtask

    initial begin
        for (int w = 0; w < 1024; w++) mem[w] = (w < 81) ? 32'(w + 1) : 32'(w - 81);
        test_reset();
        test_setup_no_valid();
        test_sweep();
        test_wrap();
        test_busy_drop();
        test_ignored();
        test_stall();
        test_reset_mid();
        test_random();
        repeat (10) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected: %0d results never arrived", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end
endmodule
